demux_1by8_tdm: RTL and testbench

- Receive-side counterpart of the 8:1 select mux: it de-multiplexes a time-division serial bit stream back into 8 parallel channel bits.
- One bit arrives per accepted cycle, tagged by slot position. A frame_sync marks slot 0.
- The block tracks slot position, detects framing errors, and presents each complete frame as a registered 8-bit word with a one-cycle valid pulse.
- It sits between the serial link and the channel-parallel logic.

---
 rtl/demux_pkg.sv | 11 +
 rtl/tdm_slot_counter.sv | 41 ++++
 rtl/demux_1by8_tdm.sv | 120 ++++++++++++
 tb/tb_demux_1by8_tdm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and defaults for the TDM receive-side demultiplexer.
package demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEFAULT_NUM_SLOTS = 8;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_SLOTS slot counter with clear, load-to-1 and increment controls.
module tdm_slot_counter #(
  parameter int NUM_SLOTS = 8,
  parameter int SEL_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load1_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  // Clear beats load beats increment; NUM_SLOTS is a power of 2 so the add wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SEL_W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == SEL_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/demux_1by8_tdm.sv
// TDM serial-to-parallel demultiplexer: tracks slot position from frame_sync,
// flags framing errors and emits each complete frame as a registered word.
module demux_1by8_tdm
  import demux_pkg::*;
#(
  parameter int NUM_SLOTS    = DEFAULT_NUM_SLOTS,
  parameter int SEL_W        = $clog2(NUM_SLOTS),
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NUM_SLOTS-1:0] dout,
  output logic                 dout_valid,
  output logic [SEL_W-1:0]     slot,
  output logic                 locked,
  output logic                 sync_err
);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] stage_q, stage_d;
  logic [NUM_SLOTS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 err_q, err_d;

  logic                 cnt_en;
  logic                 cnt_load1;
  logic                 cnt_clr;
  logic [SEL_W-1:0]     slot_cnt;
  logic                 slot_tc;
  logic                 slot_zero;

  // A new frame always starts from an empty staging word.
  function automatic logic [NUM_SLOTS-1:0] first_bit(input logic b);
    logic [NUM_SLOTS-1:0] v;
    v    = '0;
    v[0] = b;
    return v;
  endfunction

  tdm_slot_counter #(
    .NUM_SLOTS (NUM_SLOTS),
    .SEL_W     (SEL_W)
  ) u_slot_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .cnt_o   (slot_cnt),
    .tc_o    (slot_tc)
  );

  assign slot_zero = (slot_cnt == '0);

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    cnt_en    = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          stage_d   = first_bit(din);
          cnt_load1 = 1'b1;
          state_d   = LOCKED;
        end
      end else if (frame_sync && !slot_zero) begin
        // Early sync: abandon the partial frame and restart at slot 0.
        err_d     = 1'b1;
        stage_d   = first_bit(din);
        cnt_load1 = 1'b1;
      end else if (slot_zero && !frame_sync && REQUIRE_SYNC) begin
        err_d   = 1'b1;
        cnt_clr = 1'b1;
        state_d = HUNT;
      end else begin
        if (slot_zero) begin
          stage_d = first_bit(din);
        end else begin
          stage_d[slot_cnt] = din;
        end
        cnt_en = 1'b1;
        if (slot_tc) begin
          dout_d = stage_d;
          dv_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      stage_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign slot       = slot_cnt;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = err_q;

endmodule

// File: tb/tb_demux_1by8_tdm.sv
// Directed self-checking bench for demux_1by8_tdm (NUM_SLOTS=8, REQUIRE_SYNC=1).
module tb_demux_1by8_tdm;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int checks;
  int errors;
  int dv_cnt;
  int se_cnt;

  demux_1by8_tdm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, let one rising edge pass, observe pulses 1ns later.
  task automatic step(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    if (dout_valid === 1'b1) dv_cnt++;
    if (sync_err === 1'b1) se_cnt++;
  endtask

  // Bit k of b goes out on slot k, sync on slot 0, valid every cycle.
  task automatic send_frame(input logic [7:0] b);
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0), b[k]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    dv_cnt = 0; se_cnt = 0;
    #12;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", dout_valid); end
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL reset_slot got %0d exp 0", slot); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sync_err); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_frame;
    logic bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int dv0;
    dv0 = dv_cnt;
    step(1'b1, 1'b1, bits[0]);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b exp 1", locked); end
    checks++; if (slot !== 3'd1) begin errors++; $display("FAIL single_slot1 got %0d exp 1", slot); end
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, bits[k]);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_dv got %b exp 1", dout_valid); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL single_dout got %h exp 4d", dout); end
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL single_wrap got %0d exp 0", slot); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_dv_pulse got %b exp 0", dout_valid); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL single_hold got %h exp 4d", dout); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count got %0d exp 1", dv_cnt - dv0); end
    checks++; if (se_cnt !== 0) begin errors++; $display("FAIL single_no_err got %0d exp 0", se_cnt); end
  endtask

  task automatic test_gapped;
    logic [7:0] b = 8'b0100_1101;
    int dv0;
    dv0 = dv_cnt;
    for (int k = 0; k < 4; k++) step(1'b1, (k == 0), b[k]);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++; if (slot !== 3'd4) begin errors++; $display("FAIL gap_slot got %0d exp 4", slot); end
    end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL gap_early_dv got %0d exp %0d", dv_cnt, dv0); end
    for (int k = 4; k < 8; k++) step(1'b1, 1'b0, b[k]);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gap_dv got %b exp 1", dout_valid); end
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL gap_dout got %h exp 4d", dout); end
    checks++; if (se_cnt !== 0) begin errors++; $display("FAIL gap_no_err got %0d exp 0", se_cnt); end
  endtask

  task automatic test_back_to_back;
    send_frame(8'hFF);
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL b2b_doutA got %h exp ff", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_dvA got %b exp 1", dout_valid); end
    // Frame B: slots 1,3,5,7 set.
    step(1'b1, 1'b1, 1'b0);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_dv_gap got %b exp 0", dout_valid); end
    checks++; if (slot !== 3'd1) begin errors++; $display("FAIL b2b_slot got %0d exp 1", slot); end
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, (k % 2 == 1));
    checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL b2b_doutB got %h exp aa", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_dvB got %b exp 1", dout_valid); end
  endtask

  task automatic test_early_sync;
    int dv0;
    int se0;
    dv0 = dv_cnt;
    se0 = se_cnt;
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL early_err got %b exp 1", sync_err); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL early_dv got %b exp 0", dout_valid); end
    checks++; if (slot !== 3'd1) begin errors++; $display("FAIL early_slot got %0d exp 1", slot); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL early_locked got %b exp 1", locked); end
    checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL early_dout_hold got %h exp aa", dout); end
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL early_dout got %h exp 01", dout); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL early_dv_count got %0d exp 1", dv_cnt - dv0); end
    checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL early_err_count got %0d exp 1", se_cnt - se0); end
  endtask

  task automatic test_missing_sync;
    int dv0;
    send_frame(8'h0F);
    checks++; if (dout !== 8'h0F) begin errors++; $display("FAIL miss_frame got %h exp 0f", dout); end
    step(1'b1, 1'b0, 1'b1);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL miss_err got %b exp 1", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss_locked got %b exp 0", locked); end
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL miss_slot got %0d exp 0", slot); end
    dv0 = dv_cnt;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, k[0]);
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL miss_ignored_dv got %0d exp %0d", dv_cnt, dv0); end
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL miss_ignored_slot got %0d exp 0", slot); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss_ignored_locked got %b exp 0", locked); end
  endtask

  task automatic test_hunt_discard;
    int dv0;
    dv0 = dv_cnt;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL hunt_dv got %0d exp %0d", dv_cnt, dv0); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hunt_locked got %b exp 0", locked); end
    send_frame(8'hFF);
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL hunt_dout got %h exp ff", dout); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL hunt_dv_count got %0d exp 1", dv_cnt - dv0); end
  endtask

  task automatic test_async_reset;
    int dv0;
    for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b1);
    checks++; if (slot !== 3'd5) begin errors++; $display("FAIL arst_pre_slot got %0d exp 5", slot); end
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL arst_dout got %h exp 00", dout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %b exp 0", locked); end
    checks++; if (slot !== 3'd0) begin errors++; $display("FAIL arst_slot got %0d exp 0", slot); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL arst_dv got %b exp 0", dout_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    dv0 = dv_cnt;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1);
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL arst_no_dv got %0d exp %0d", dv_cnt, dv0); end
    send_frame(8'h4D);
    checks++; if (dout !== 8'h4D) begin errors++; $display("FAIL arst_frame got %h exp 4d", dout); end
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL arst_dv_count got %0d exp 1", dv_cnt - dv0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_hunt_discard();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
